// File: rtl/text_render_pipe_if.sv
// text_render_pipe_if: raster, memory and pixel bus of the text renderer.
//   slave  : renderer side (raster/timing, memory read data and palette
//            writes in; memory addresses, RGB and delayed timing out)
//   master : raster source / memory / display side
interface text_render_pipe_if #(
  parameter int CPW     = 2,
  parameter int VRAM_AW = 11
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               vde_in;
  logic               hs_in;
  logic               vs_in;
  logic [VRAM_AW-1:0] vram_addr;
  logic [16*CPW-1:0]  vram_q;
  logic [10:0]        font_addr;
  logic [7:0]         font_data;
  logic               pal_we;
  logic [3:0]         pal_addr;
  logic [11:0]        pal_wdata;
  logic [6:0]         cursor_col;
  logic [4:0]         cursor_row;
  logic [3:0]         Red;
  logic [3:0]         Green;
  logic [3:0]         Blue;
  logic               vde_out;
  logic               hs_out;
  logic               vs_out;

  modport slave (
    input  DrawX, DrawY, vde_in, hs_in, vs_in, vram_q, font_data,
           pal_we, pal_addr, pal_wdata, cursor_col, cursor_row,
    output vram_addr, font_addr, Red, Green, Blue, vde_out, hs_out, vs_out
  );

  modport master (
    output DrawX, DrawY, vde_in, hs_in, vs_in, vram_q, font_data,
           pal_we, pal_addr, pal_wdata, cursor_col, cursor_row,
    input  vram_addr, font_addr, Red, Green, Blue, vde_out, hs_out, vs_out
  );
endinterface

// File: rtl/text_render_pipe.sv
// text_render_pipe: 3-stage text-mode pixel renderer.
//   stage 0 (comb) : raster -> VRAM word address
//   stage 1        : slot select from vram_q -> font ROM address
//   stage 2        : glyph bit -> palette lookup, RGB registered at stage 3
// Ports: clk, reset (async, active high), bus (text_render_pipe_if.slave).
// Optional macro TEXT_RENDER_CURSOR_EN: blinking underline cursor driven by
// a frame counter on vs_in rising edges; without it the cursor ports are
// ignored and the blink phase is constantly 0.
module text_render_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CPW          = 2,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int VRAM_AW      = 11,
  parameter int BLINK_FRAMES = 30
)(
  input logic             clk,
  input logic             reset,
  text_render_pipe_if.slave bus
);
  localparam int  LW  = $clog2(GLYPH_H);
  localparam int  SW  = (CPW > 1) ? $clog2(CPW) : 1;
  localparam int  WPR = COLS / CPW;
  localparam bit  CFG_OK = (GLYPH_W == 8) && (COLS % CPW == 0) &&
                           (CPW == 1 || CPW == 2 || CPW == 4) &&
                           ((1 << LW) == GLYPH_H) && (BLINK_FRAMES >= 1) &&
                           (ROWS * COLS / CPW <= (1 << VRAM_AW));

  if (!CFG_OK) begin : g_bad_cfg
    $error("text_render_pipe: illegal parameter combination");
  end

  // ---------------- stage 0: addressing ----------------
  logic [9:0]    col0, row0;
  logic          in_rng0, vld0, cur0, phase;
  logic [SW-1:0] slot0;
  logic [LW-1:0] line0;
  logic [2:0]    px0;

  always_comb begin
    col0    = bus.DrawX / 10'(GLYPH_W);
    row0    = bus.DrawY / 10'(GLYPH_H);
    in_rng0 = (32'(col0) < 32'(COLS)) && (32'(row0) < 32'(ROWS));
    vld0    = bus.vde_in & in_rng0;
    slot0   = SW'(32'(col0) % 32'(CPW));
    line0   = bus.DrawY[LW-1:0];
    px0     = bus.DrawX[2:0];
  end

  // Off-screen pixels fetch word 0; their vde is killed so the data is moot.
  assign bus.vram_addr = in_rng0 ?
    VRAM_AW'(32'(row0) * 32'(WPR) + 32'(col0) / 32'(CPW)) : '0;

`ifdef TEXT_RENDER_CURSOR_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic          vs_prev_q, phase_q;
  logic [FW-1:0] frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      frame_q   <= '0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= bus.vs_in;
      if (bus.vs_in && !vs_prev_q) begin
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

  // Underline cursor: bottom two glyph lines of the cursor cell.
  assign cur0  = (col0 == 10'(bus.cursor_col)) && (row0 == 10'(bus.cursor_row)) &&
                 (32'(line0) >= 32'(GLYPH_H - 2));
  assign phase = phase_q;
`else
  assign cur0  = 1'b0;
  assign phase = 1'b0;
`endif

  // ---------------- pipeline registers ----------------
  logic [SW-1:0]     slot1_q;
  logic [LW-1:0]     line1_q;
  logic [2:0]        px1_q, px2_q;
  logic              cur1_q, cur2_q, inv2_q;
  logic [3:0]        fg2_q, bg2_q;
  logic [3:1]        vld_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [11:0]       rgb_q;
  logic [15:0][11:0] pal_q;

  // ---------------- stage 1: slot select, font address ----------------
  logic [15:0] slot1;
  assign slot1 = bus.vram_q[16*slot1_q +: 16];
  // Held at 0 during reset even if vram_q still carries stale data.
  assign bus.font_addr = reset ? '0 :
    11'(32'(slot1[14:8]) * 32'(GLYPH_H) + 32'(line1_q));

  // ---------------- stage 2: pixel bit, palette ----------------
  logic        bit2;
  logic [3:0]  idx2;
  logic [11:0] rgb_d;

  always_comb begin
    bit2  = bus.font_data[3'd7 - px2_q] ^ inv2_q ^ (cur2_q & phase);
    idx2  = bit2 ? fg2_q : bg2_q;
    // Palette is read before this edge's write lands: same-edge read sees old value.
    rgb_d = vld_pipe_q[2] ? pal_q[idx2] : 12'h000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot1_q    <= '0;
      line1_q    <= '0;
      px1_q      <= '0;
      cur1_q     <= 1'b0;
      px2_q      <= '0;
      cur2_q     <= 1'b0;
      inv2_q     <= 1'b0;
      fg2_q      <= '0;
      bg2_q      <= '0;
      vld_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      rgb_q      <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
    end else begin
      slot1_q    <= slot0;
      line1_q    <= line0;
      px1_q      <= px0;
      cur1_q     <= cur0;
      px2_q      <= px1_q;
      cur2_q     <= cur1_q;
      inv2_q     <= slot1[15];
      fg2_q      <= slot1[7:4];
      bg2_q      <= slot1[3:0];
      vld_pipe_q <= {vld_pipe_q[2:1], vld0};
      hs_pipe_q  <= {hs_pipe_q[2:1], bus.hs_in};
      vs_pipe_q  <= {vs_pipe_q[2:1], bus.vs_in};
      rgb_q      <= rgb_d;
      if (bus.pal_we) pal_q[bus.pal_addr] <= bus.pal_wdata;
    end
  end

  assign bus.Red     = rgb_q[11:8];
  assign bus.Green   = rgb_q[7:4];
  assign bus.Blue    = rgb_q[3:0];
  assign bus.vde_out = vld_pipe_q[3];
  assign bus.hs_out  = hs_pipe_q[3];
  assign bus.vs_out  = vs_pipe_q[3];
endmodule

// File: tb/tb_text_render_pipe.sv
module tb_text_render_pipe;
  localparam int COLS = 80, ROWS = 30, CPW = 2, GH = 16, VAW = 11;
`ifdef TEXT_RENDER_CURSOR_EN
  localparam int BF = 2;
`else
  localparam int BF = 30;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_render_pipe_if #(.CPW(CPW), .VRAM_AW(VAW)) bus ();
  text_render_pipe #(.COLS(COLS), .ROWS(ROWS), .CPW(CPW), .GLYPH_W(8), .GLYPH_H(GH),
                     .VRAM_AW(VAW), .BLINK_FRAMES(BF))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // synchronous memories outside the renderer
  logic [31:0] vram_m [2048];
  logic [7:0]  font_m [2048];
  always @(posedge clk) begin
    bus.vram_q    <= vram_m[bus.vram_addr];
    bus.font_data <= font_m[bus.font_addr];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic vde, hs, vs, cur, bitv;
    logic [3:0] fg, bg;
  } rec_t;
  rec_t        pq[$];
  logic [11:0] pal_m [16];
  int          frames;
  logic        vs_last_m;
  int          nvec = 0, nfail = 0;

  function automatic rec_t mk();
    rec_t r; int col, row, line, px; bit inr;
    logic [31:0] w; logic [15:0] ch; logic [7:0] g;
    col  = int'(bus.DrawX) / 8;  row = int'(bus.DrawY) / GH;
    line = int'(bus.DrawY) % GH; px  = int'(bus.DrawX) % 8;
    inr  = (col < COLS) && (row < ROWS);
    w    = vram_m[inr ? row * (COLS / CPW) + col / CPW : 0];
    ch   = w[16 * (col % CPW) +: 16];
    g    = font_m[int'(ch[14:8]) * GH + line];
    r.bitv = g[7 - px] ^ ch[15];
    r.fg = ch[7:4]; r.bg = ch[3:0];
    r.vde = bus.vde_in & inr; r.hs = bus.hs_in; r.vs = bus.vs_in;
    r.cur = 1'b0;
`ifdef TEXT_RENDER_CURSOR_EN
    r.cur = (col == int'(bus.cursor_col)) && (row == int'(bus.cursor_row)) && (line >= GH - 2);
`endif
    return r;
  endfunction

  function automatic logic [14:0] resolve(rec_t r);
    logic b; logic [11:0] c;
    b = r.bitv ^ (r.cur & (((frames / BF) % 2) == 1));
    c = r.vde ? pal_m[b ? r.fg : r.bg] : 12'h000;
    return {c, r.vde, r.hs, r.vs};
  endfunction

  function automatic logic [14:0] outs();
    return {bus.Red, bus.Green, bus.Blue, bus.vde_out, bus.hs_out, bus.vs_out};
  endfunction

  function automatic logic [10:0] exp_addr(int x, int y);
    int c, r;
    c = x / 8; r = y / GH;
    return (c < COLS && r < ROWS) ? 11'(r * (COLS / CPW) + c / CPW) : 11'd0;
  endfunction

  task automatic model_reset();
    pq.delete();
    pq.push_back('0);
    pq.push_back('0);
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
    frames = 0;
    vs_last_m = 1'b0;
  endtask

  // One clock: enqueue current inputs, resolve the pixel now in stage 2,
  // apply palette write / vs edge to the model, then sample after the edge.
  task automatic tick(output logic [14:0] e);
    pq.push_back(mk());
    e = resolve(pq[0]);
    if (bus.pal_we) pal_m[bus.pal_addr] = bus.pal_wdata;
    if (bus.vs_in && !vs_last_m) frames++;
    vs_last_m = bus.vs_in;
    @(posedge clk); #1;
    void'(pq.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nvec++;
    if (outs() !== 15'h0) begin nfail++; $display("FAIL reset_out: got %h want 0", outs()); end
    nvec++;
    if (bus.font_addr !== 11'h0) begin nfail++; $display("FAIL reset_font_addr: got %h want 0", bus.font_addr); end
    @(posedge clk); @(posedge clk); #1;
    nvec++;
    if (outs() !== 15'h0) begin nfail++; $display("FAIL reset_hold: got %h want 0", outs()); end
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_blank();
    logic [14:0] e;
    for (int i = 0; i < 42; i++) begin
      bus.DrawX = 10'($urandom_range(0, 639)); bus.DrawY = 10'($urandom_range(0, 479));
      bus.vde_in = (i < 40); bus.hs_in = 1'($urandom); bus.vs_in = 1'($urandom);
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL blank_model i=%0d: got %h want %h", i, outs(), e); end
      if (i >= 2) begin
        nvec++;
        if (outs()[14:2] !== 13'h1) begin nfail++; $display("FAIL blank_const i=%0d: got %h want rgb 0 vde 1", i, outs()); end
      end
    end
  endtask

  task automatic test_pattern();
    logic [14:0] e; int y; logic [7:0] g; logic [11:0] c;
    y = $urandom_range(0, 15);
    for (int i = 0; i < 18; i++) begin
      bus.DrawX = 10'(i < 16 ? i : 0); bus.DrawY = 10'(y);
      bus.vde_in = (i < 16); bus.hs_in = 1'b0; bus.vs_in = 1'b0;
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL pattern_model i=%0d: got %h want %h", i, outs(), e); end
      if (i >= 2) begin
        if (i - 2 < 8) c = (i - 2 == 0 || i - 2 == 7) ? 12'h111 : 12'h222;
        else begin
          g = font_m[8'h0B * GH + y];
          c = g[7 - (i - 10)] ? 12'h111 : 12'h222;
        end
        nvec++;
        if (outs()[14:3] !== c) begin nfail++; $display("FAIL pattern_const x=%0d: got %h want %h", i - 2, outs()[14:3], c); end
      end
    end
  endtask

  task automatic test_pal_write();
    logic [14:0] e; logic [11:0] c;
    for (int i = 0; i < 8; i++) begin
      bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.vde_in = (i < 6);
      bus.pal_we = (i == 2); bus.pal_addr = 4'd1; bus.pal_wdata = 12'hF00;
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL palwr_model i=%0d: got %h want %h", i, outs(), e); end
      if (i >= 2 && i < 8) begin
        c = (i == 2) ? 12'h111 : 12'hF00;
        nvec++;
        if (outs()[14:3] !== c) begin nfail++; $display("FAIL palwr_const i=%0d: got %h want %h", i, outs()[14:3], c); end
      end
    end
    bus.pal_we = 1'b0;
  endtask

  task automatic test_range();
    logic [14:0] e;
    int xs[5] = '{639, 700, 100, 0, 0};
    int ys[5] = '{479, 479, 490, 0, 0};
    logic [10:0] ca[5] = '{11'd1199, 11'd0, 11'd0, 11'd0, 11'd0};
    for (int i = 0; i < 5; i++) begin
      bus.DrawX = 10'(xs[i]); bus.DrawY = 10'(ys[i]); bus.vde_in = (i < 3);
      #1;
      nvec++;
      if (bus.vram_addr !== ca[i]) begin nfail++; $display("FAIL range_addr i=%0d: got %0d want %0d", i, bus.vram_addr, ca[i]); end
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL range_model i=%0d: got %h want %h", i, outs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e;
    for (int i = 0; i < 4; i++) begin
      bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.vde_in = 1'b1; bus.hs_in = 1'b1;
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL rstmid_pre i=%0d: got %h want %h", i, outs(), e); end
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (outs() !== 15'h0) begin nfail++; $display("FAIL rstmid_async: got %h want 0", outs()); end
    nvec++;
    if (bus.font_addr !== 11'h0) begin nfail++; $display("FAIL rstmid_font_addr: got %h want 0", bus.font_addr); end
    @(posedge clk); @(posedge clk); #1;
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      bus.vde_in = (i < 4); bus.hs_in = 1'b0;
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL rstmid_model i=%0d: got %h want %h", i, outs(), e); end
      if (i >= 2) begin
        nvec++;
        if (outs()[14:2] !== {12'h111, 1'b1}) begin nfail++; $display("FAIL rstmid_ramp i=%0d: got %h want 111/vde 1", i, outs()); end
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] e; int x, y;
    for (int a = 0; a < 2048; a++) begin vram_m[a] = $urandom; font_m[a] = 8'($urandom); end
    for (int i = 0; i < 302; i++) begin
      x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.vde_in = (i < 300) && ($urandom_range(0, 7) != 0);
      bus.hs_in = 1'($urandom); bus.vs_in = 1'($urandom);
      bus.pal_we = (i < 300) && ($urandom_range(0, 7) == 0);
      bus.pal_addr = 4'($urandom); bus.pal_wdata = 12'($urandom);
      #1;
      nvec++;
      if (bus.vram_addr !== exp_addr(x, y)) begin nfail++; $display("FAIL rand_addr x=%0d y=%0d: got %0d want %0d", x, y, bus.vram_addr, exp_addr(x, y)); end
      tick(e);
      nvec++;
      if (outs() !== e) begin nfail++; $display("FAIL rand_model i=%0d: got %h want %h", i, outs(), e); end
    end
    bus.pal_we = 1'b0; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
  endtask

  task automatic test_cursor();
    logic [14:0] e;
    bus.cursor_col = 7'd3; bus.cursor_row = 5'd2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 100; i++) begin
        bus.vs_in = (i == 99); bus.vde_in = (i < 96);
        bus.DrawX = 10'(16 + (i % 24)); bus.DrawY = 10'(44 + (i / 24) % 4);
        tick(e);
        nvec++;
        if (outs() !== e) begin nfail++; $display("FAIL cursor f=%0d i=%0d: got %h want %h", f, i, outs(), e); end
      end
    end
    bus.vs_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.DrawX = '0; bus.DrawY = '0; bus.vde_in = 1'b0; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
    bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_wdata = '0;
    bus.cursor_col = 7'd3; bus.cursor_row = 5'd2;
    for (int a = 0; a < 2048; a++) begin vram_m[a] = 32'h0; font_m[a] = 8'($urandom); end
    model_reset();
    #1;
    test_reset();
    test_blank();
    vram_m[0] = {16'h8B21, 16'h4112};
    for (int l = 0; l < GH; l++) font_m[8'h41 * GH + l] = 8'h81;
    test_pattern();
    test_pal_write();
    test_range();
    test_reset_mid();
    test_random();
    test_cursor();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/text_render_pipe.md
Name: text_render_pipe

Overview:
- Parametrised, pipelined text-mode pixel renderer for the HDMI/VGA path.
- Takes the raster position and the timing signals from the VGA controller.
- Fetches the character word from synchronous VRAM, then the glyph row from the synchronous font ROM, then resolves fg/bg through an internal writable palette.
- Emits registered 12-bit RGB with fixed latency, plus raster timing delayed to match.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows.
- CPW, 2, characters packed per VRAM word. Legal values 1, 2, 4; COLS % CPW == 0.
- GLYPH_W, 8, glyph width in pixels. Fixed at 8 (font_data width).
- GLYPH_H, 16, glyph height in pixels. Power of 2.
- VRAM_AW, 11, VRAM word address width. Must satisfy ROWS*COLS/CPW <= 2^VRAM_AW.
- BLINK_FRAMES, 30, frames per cursor blink half-period (CURSOR_EN only).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- vde_in  in  1  active-video flag for (DrawX, DrawY).
- hs_in  in  1  raw horizontal sync.
- vs_in  in  1  raw vertical sync.
- vram_addr  out  VRAM_AW  VRAM word address. Combinational from DrawX/DrawY.
- vram_q  in  16*CPW  VRAM read data. Valid one cycle after vram_addr.
- font_addr  out  11  font ROM address = code*GLYPH_H + line.
- font_data  in  8  glyph row. Valid one cycle after font_addr.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry index.
- pal_wdata  in  12  palette entry value {R[3:0],G[3:0],B[3:0]}.
- cursor_col  in  7  cursor text column. Ignored without CURSOR_EN.
- cursor_row  in  5  cursor text row. Ignored without CURSOR_EN.
- Red, Green, Blue  out  4 each  pixel colour.
- vde_out, hs_out, vs_out  out  1 each  timing delayed to align with RGB.

Behaviour:
- Character slot format (16 bits): [15] invert, [14:8] code, [7:4] fg index, [3:0] bg index.
- Slot k of vram_q occupies bits [16k+15:16k]; slot 0 is the leftmost character.
- Addressing, stage 0 (comb):
  - col = DrawX/GLYPH_W, row = DrawY/GLYPH_H.
  - vram_addr = row*(COLS/CPW) + col/CPW.
  - Stage-1 regs capture slot = col%CPW, line = DrawY%GLYPH_H, px = DrawX%GLYPH_W, vde, hs, vs, and the cursor hit.
- Stage 1: select the slot from vram_q and drive font_addr combinationally. Stage-2 regs capture invert, fg, bg, px, and the timing signals.
- Stage 2: bit = font_data[7-px] XOR invert, then palette lookup (fg if bit=1, else bg). RGB and the delayed timing are registered at the stage-3 edge.
- Latency: inputs presented on cycle N appear on Red/Green/Blue and vde_out/hs_out/vs_out at cycle N+3, back-to-back every cycle, no stalls.
- When the delayed vde is 0, RGB = 0.
- Palette:
  - 16 x 12-bit registers.
  - Reset value of entry i is {i,i,i} (grayscale ramp).
  - A write takes effect at the clk edge where pal_we=1.
  - A pixel resolving the same entry on that edge uses the old value.
- Reset (async, any time, including mid-frame):
  - All pipeline registers clear; RGB=0; vde_out=hs_out=vs_out=0; palette returns to the ramp.
  - font_addr reads 0 while reset is held.
  - Output resumes 3 cycles after deassertion.
- Out-of-range DrawX/DrawY (col>=COLS or row>=ROWS): vram_addr is forced to 0 and that pixel's vde is forced to 0 through the pipe.

Optional Feature:
- Macro: TEXT_RENDER_CURSOR_EN.
- Defined:
  - A frame counter increments on each rising edge of vs_in.
  - The blink phase toggles every BLINK_FRAMES frames; counter and phase reset to 0.
  - A pixel is a cursor pixel when (col,row)==(cursor_col,cursor_row) and line >= GLYPH_H-2.
  - If the blink phase is 1, bit is inverted again at stage 2.
- Undefined: cursor ports are present but unused, there is no frame counter, and output is identical to phase 0 at all times.

Test Plan:
- After reset, VRAM model returns 16'h0000 in every slot, all pixels active → RGB = 0x000 and vde_out = 1 three cycles after each input; reset values checked before the first edge.
- Word {16'h8B21, 16'h4112} at addr 0, CPW=2, font row for code 0x41 = 8'h81 → DrawX=0..7 gives fg entry 1 (0x111) at px 0 and 7, bg entry 2 (0x222) elsewhere; DrawX=8..15 (code 0x0B, invert) gives colours swapped relative to the font bits.
- pal_we with pal_addr=1, pal_wdata=12'hF00 on the same edge a fg=1 pixel is in stage 2 → that pixel is 0x111; the next such pixel is 0xF00.
- DrawY=479, DrawX=639 (row 29, col 79) → vram_addr = 29*40+39 = 1199; DrawX=700 → vram_addr = 0, vde_out = 0.
- Assert reset mid-line for 2 cycles → outputs 0 immediately (async), palette returns to the ramp, valid pixels resume at cycle 3 after release.
- CURSOR_EN, BLINK_FRAMES=2, cursor (3,2) → lines 14-15 of that cell inverted during frames 2-3, normal during frames 0-1 and 4-5.
